control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: walks fetch/decode/execute for a small accumulator-less CPU
// and drives datapath, memory and stack strobes combinationally from the current state.
module control_sequencer #(
    parameter int unsigned NREG   = 4,
    parameter int unsigned IR_W   = 8,
    parameter int unsigned FLAG_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IR_W-1:0]           IR_out,
    input  logic [FLAG_W-1:0]         flag_out,
    input  logic                      mem_ready,
    input  logic                      stack_full,
    input  logic                      stack_empty,
    output logic [NREG-1:0]           load_reg,
    output logic                      inc_PC,
    output logic                      load_PC,
    output logic                      load_Add_R,
    output logic                      load_Reg_Z,
    output logic                      load_IR,
    output logic [1:0]                opcode,
    output logic [$clog2(NREG):0]     Mux_1_sel,
    output logic [1:0]                Mux_2_sel,
    output logic                      read,
    output logic                      write,
    output logic                      push,
    output logic                      pop,
    output logic                      halted
);

    localparam int unsigned RIDX = $clog2(NREG);
    localparam int unsigned CIDX = $clog2(FLAG_W);
    localparam int unsigned CW   = RIDX + 1;

    localparam logic [3:0] FETCH1    = 4'd0;
    localparam logic [3:0] FETCH2    = 4'd1;
    localparam logic [3:0] EXEC      = 4'd2;
    localparam logic [3:0] OPND      = 4'd3;
    localparam logic [3:0] MEM_RD    = 4'd4;
    localparam logic [3:0] MEM_WR    = 4'd5;
    localparam logic [3:0] BRANCH    = 4'd6;
    localparam logic [3:0] CALL_PUSH = 4'd7;
    localparam logic [3:0] CALL_JMP  = 4'd8;
    localparam logic [3:0] RET_POP   = 4'd9;
    localparam logic [3:0] RET_PC    = 4'd10;
    localparam logic [3:0] HALT      = 4'd11;

    localparam logic [CW-1:0]   SelPc    = CW'(NREG);
    localparam logic [CW-1:0]   SelIdle  = CW'(NREG + 1);
    localparam logic [CW-1:0]   PushLast = CW'(NREG);
    localparam logic [CW-1:0]   PopLast  = CW'(NREG - 1);
    localparam logic [NREG-1:0] OneHot0  = NREG'(1);

    logic [3:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      op;
    logic [RIDX-1:0] rd;
    logic [RIDX-1:0] rs;
    logic [CIDX-1:0] cond;

    assign op   = IR_out[IR_W-1 -: 4];
    assign rd   = IR_out[RIDX-1:0];
    assign rs   = IR_out[2*RIDX-1:RIDX];
    assign cond = IR_out[CIDX-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_reg   = '0;
        inc_PC     = 1'b0;
        load_PC    = 1'b0;
        load_Add_R = 1'b0;
        load_Reg_Z = 1'b0;
        load_IR    = 1'b0;
        opcode     = 2'd3;
        Mux_1_sel  = SelIdle;
        Mux_2_sel  = 2'd0;
        read       = 1'b0;
        write      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        halted     = 1'b0;

        // Reset gates the outputs too, so nothing leaks while the state register is held.
        if (!rst) begin
            case (state_q)
                FETCH1: begin
                    Mux_1_sel  = SelPc;
                    Mux_2_sel  = 2'd1;
                    load_Add_R = 1'b1;
                    state_d    = FETCH2;
                end
                FETCH2: begin
                    read      = 1'b1;
                    Mux_2_sel = 2'd2;
                    if (mem_ready) begin
                        load_IR = 1'b1;
                        inc_PC  = 1'b1;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    cnt_d = '0;
                    case (op)
                        4'h0, 4'h1, 4'h2: begin
                            opcode     = op[1:0];
                            load_Reg_Z = 1'b1;
                            state_d    = FETCH1;
                        end
                        4'h3, 4'h4, 4'h8: state_d = OPND;
                        4'h5: begin
                            // Point Add_R at the operand byte before the jump target read.
                            Mux_1_sel  = SelPc;
                            Mux_2_sel  = 2'd1;
                            load_Add_R = 1'b1;
                            state_d    = BRANCH;
                        end
                        4'h6: begin
                            Mux_1_sel    = {1'b0, rs};
                            Mux_2_sel    = 2'd1;
                            load_reg     = OneHot0 << rd;
                            state_d      = FETCH1;
                        end
                        4'h7: begin
                            Mux_1_sel  = {1'b0, rs};
                            Mux_2_sel  = 2'd1;
                            load_Add_R = 1'b1;
                            state_d    = MEM_RD;
                        end
                        4'h9: begin
                            if (flag_out[cond]) begin
                                Mux_1_sel  = SelPc;
                                Mux_2_sel  = 2'd1;
                                load_Add_R = 1'b1;
                                state_d    = BRANCH;
                            end else begin
                                inc_PC  = 1'b1;
                                state_d = FETCH1;
                            end
                        end
                        4'hA: begin
                            Mux_1_sel  = SelPc;
                            Mux_2_sel  = 2'd1;
                            load_Add_R = 1'b1;
                            inc_PC     = 1'b1;
                            state_d    = CALL_PUSH;
                        end
                        4'hB:    state_d = RET_POP;
                        default: state_d = HALT;
                    endcase
                end
                OPND: begin
                    // The counter splits OPND into an address phase (0) and a read phase (1).
                    if (cnt_q == '0) begin
                        Mux_1_sel  = SelPc;
                        Mux_2_sel  = 2'd1;
                        load_Add_R = 1'b1;
                        cnt_d      = CW'(1);
                    end else begin
                        read      = 1'b1;
                        Mux_2_sel = 2'd2;
                        if (mem_ready) begin
                            inc_PC = 1'b1;
                            if (op == 4'h3) begin
                                load_reg = OneHot0 << rd;
                                state_d  = FETCH1;
                            end else begin
                                load_Add_R = 1'b1;
                                state_d    = (op == 4'h4) ? MEM_RD : MEM_WR;
                            end
                        end
                    end
                end
                MEM_RD: begin
                    read      = 1'b1;
                    Mux_2_sel = 2'd2;
                    if (mem_ready) begin
                        load_reg = OneHot0 << rd;
                        state_d  = FETCH1;
                    end
                end
                MEM_WR: begin
                    write     = 1'b1;
                    Mux_1_sel = {1'b0, rs};
                    Mux_2_sel = 2'd3;
                    if (mem_ready) begin
                        state_d = FETCH1;
                    end
                end
                BRANCH, CALL_JMP: begin
                    read      = 1'b1;
                    Mux_2_sel = 2'd2;
                    if (mem_ready) begin
                        load_PC = 1'b1;
                        state_d = FETCH1;
                    end
                end
                CALL_PUSH: begin
                    if (stack_full) begin
                        state_d = HALT;
                    end else begin
                        push      = 1'b1;
                        Mux_2_sel = 2'd3;
                        Mux_1_sel = (cnt_q == '0) ? SelPc : cnt_q - CW'(1);
                        cnt_d     = cnt_q + CW'(1);
                        if (cnt_q == PushLast) begin
                            state_d = CALL_JMP;
                        end
                    end
                end
                RET_POP: begin
                    if (stack_empty) begin
                        state_d = HALT;
                    end else begin
                        pop       = 1'b1;
                        Mux_2_sel = 2'd2;
                        load_reg  = OneHot0 << (PopLast - cnt_q);
                        cnt_d     = cnt_q + CW'(1);
                        if (cnt_q == PopLast) begin
                            state_d = RET_PC;
                        end
                    end
                end
                RET_PC: begin
                    if (stack_empty) begin
                        state_d = HALT;
                    end else begin
                        pop       = 1'b1;
                        Mux_2_sel = 2'd2;
                        load_PC   = 1'b1;
                        state_d   = FETCH1;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: state_d = FETCH1;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: an instruction-level model emits the expected
// per-cycle strobes, and one compare process checks every cycle against the DUT.
module tb_control_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] IR_out;
    logic [7:0] flag_out;
    logic       mem_ready;
    logic       stack_full;
    logic       stack_empty;
    logic [3:0] load_reg;
    logic       inc_PC, load_PC, load_Add_R, load_Reg_Z, load_IR;
    logic [1:0] opcode;
    logic [2:0] Mux_1_sel;
    logic [1:0] Mux_2_sel;
    logic       read, write, push, pop, halted;

    control_sequencer #(.NREG(4), .IR_W(8), .FLAG_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .IR_out     (IR_out),
        .flag_out   (flag_out),
        .mem_ready  (mem_ready),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .load_reg   (load_reg),
        .inc_PC     (inc_PC),
        .load_PC    (load_PC),
        .load_Add_R (load_Add_R),
        .load_Reg_Z (load_Reg_Z),
        .load_IR    (load_IR),
        .opcode     (opcode),
        .Mux_1_sel  (Mux_1_sel),
        .Mux_2_sel  (Mux_2_sel),
        .read       (read),
        .write      (write),
        .push       (push),
        .pop        (pop),
        .halted     (halted)
    );

    typedef struct packed {
        logic [3:0] ld_reg;
        logic       inc, ldpc, ldadd, ldz, ldir;
        logic [1:0] opc;
        logic [2:0] m1;
        logic [1:0] m2;
        logic       rd, wr, psh, pp, hlt;
    } outs_t;

    int         checks = 0;
    int         errors = 0;
    outs_t      exp_o;
    logic       exp_valid = 1'b0;
    logic [7:0] cur_ir = 8'h00;
    logic [7:0] cur_fl = 8'h00;
    logic       cnt_en = 1'b0;
    int         rd_cnt, ldir_cnt, inc_cnt;
    int         push_q[$];
    int         pop_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single compare process: every cycle the stimulus marks as meaningful.
    always @(negedge clk) begin
        outs_t act;
        #2;
        if (exp_valid) begin
            act = {load_reg, inc_PC, load_PC, load_Add_R, load_Reg_Z, load_IR, opcode,
                   Mux_1_sel, Mux_2_sel, read, write, push, pop, halted};
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL outputs t=%0t: got %h required %h", $time, act, exp_o);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (cnt_en) begin
            rd_cnt   += int'(read);
            ldir_cnt += int'(load_IR);
            inc_cnt  += int'(inc_PC);
        end
        if (!rst && push) push_q.push_back(int'(Mux_1_sel));
        if (!rst && pop && (load_reg != 4'b0)) pop_q.push_back(int'(load_reg));
    end

    task automatic lit(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, want);
        end
    endtask

    function automatic outs_t idle();
        outs_t o;
        o     = '0;
        o.opc = 2'd3;
        o.m1  = 3'd5;
        return o;
    endfunction

    function automatic outs_t pc_to_addr();
        outs_t o;
        o       = idle();
        o.m1    = 3'd4;
        o.m2    = 2'd1;
        o.ldadd = 1'b1;
        return o;
    endfunction

    function automatic outs_t mem_rd();
        outs_t o;
        o    = idle();
        o.rd = 1'b1;
        o.m2 = 2'd2;
        return o;
    endfunction

    function automatic outs_t strip(input outs_t o);
        outs_t s;
        s        = o;
        s.ld_reg = '0;
        s.inc    = 1'b0;
        s.ldpc   = 1'b0;
        s.ldadd  = 1'b0;
        s.ldir   = 1'b0;
        return s;
    endfunction

    task automatic cyc(input outs_t o, input logic rdy = 1'b1, input logic full = 1'b0,
                       input logic empty = 1'b0, input logic r = 1'b0);
        @(negedge clk);
        rst         = r;
        IR_out      = cur_ir;
        flag_out    = cur_fl;
        mem_ready   = rdy;
        stack_full  = full;
        stack_empty = empty;
        exp_o       = o;
        exp_valid   = 1'b1;
    endtask

    // Memory access: w stalled cycles with loads withheld, then the completing cycle.
    task automatic mem_wait(input outs_t o, input int w);
        repeat (w) cyc(strip(o), 1'b0);
        cyc(o);
    endtask

    // Instruction model. ab_mode 1: stack fault at push/pop k; 2: async reset after push k.
    task automatic do_instr(input logic [7:0] ir, input logic [7:0] fl, input int w = 0,
                            input int ab_k = -1, input int ab_mode = 0);
        outs_t      o;
        logic [3:0] op;
        int         rd, rs;
        cur_ir = ir;
        cur_fl = fl;
        op = ir[7:4];
        rd = int'(ir[1:0]);
        rs = int'(ir[3:2]);
        cyc(pc_to_addr());
        o = mem_rd(); o.ldir = 1'b1; o.inc = 1'b1;
        mem_wait(o, w);
        case (op)
            4'h0, 4'h1, 4'h2: begin
                o = idle(); o.opc = op[1:0]; o.ldz = 1'b1;
                cyc(o);
            end
            4'h3, 4'h4, 4'h8: begin
                cyc(idle());
                cyc(pc_to_addr());
                o = mem_rd(); o.inc = 1'b1;
                if (op == 4'h3) o.ld_reg = 4'b0001 << rd;
                else o.ldadd = 1'b1;
                mem_wait(o, w);
                if (op == 4'h4) begin
                    o = mem_rd(); o.ld_reg = 4'b0001 << rd;
                    mem_wait(o, w);
                end else if (op == 4'h8) begin
                    o = idle(); o.wr = 1'b1; o.m1 = 3'(rs); o.m2 = 2'd3;
                    mem_wait(o, w);
                end
            end
            4'h5: begin
                cyc(pc_to_addr());
                o = mem_rd(); o.ldpc = 1'b1;
                mem_wait(o, w);
            end
            4'h6: begin
                o = idle(); o.m1 = 3'(rs); o.m2 = 2'd1; o.ld_reg = 4'b0001 << rd;
                cyc(o);
            end
            4'h7: begin
                o = idle(); o.m1 = 3'(rs); o.m2 = 2'd1; o.ldadd = 1'b1;
                cyc(o);
                o = mem_rd(); o.ld_reg = 4'b0001 << rd;
                mem_wait(o, w);
            end
            4'h9: begin
                if (fl[ir[2:0]]) begin
                    cyc(pc_to_addr());
                    o = mem_rd(); o.ldpc = 1'b1;
                    mem_wait(o, w);
                end else begin
                    o = idle(); o.inc = 1'b1;
                    cyc(o);
                end
            end
            4'hA: begin
                o = pc_to_addr(); o.inc = 1'b1;
                cyc(o);
                for (int k = 0; k < 5; k++) begin
                    if (ab_mode == 1 && ab_k == k) begin
                        cyc(idle(), 1'b1, 1'b1, 1'b0);
                        return;
                    end
                    o = idle(); o.psh = 1'b1; o.m2 = 2'd3;
                    o.m1 = (k == 0) ? 3'd4 : 3'(k - 1);
                    cyc(o);
                    if (ab_mode == 2 && ab_k == k) begin
                        #3 rst = 1'b1;
                        #1;
                        lit("async reset push", int'(push), 0);
                        lit("async reset mux1", int'(Mux_1_sel), 5);
                        lit("async reset mux2", int'(Mux_2_sel), 0);
                        return;
                    end
                end
                o = mem_rd(); o.ldpc = 1'b1;
                mem_wait(o, w);
            end
            4'hB: begin
                cyc(idle());
                for (int k = 0; k < 5; k++) begin
                    if (ab_mode == 1 && ab_k == k) begin
                        cyc(idle(), 1'b1, 1'b0, 1'b1);
                        return;
                    end
                    o = idle(); o.pp = 1'b1; o.m2 = 2'd2;
                    if (k < 4) o.ld_reg = 4'b1000 >> k;
                    else o.ldpc = 1'b1;
                    cyc(o);
                end
            end
            default: begin
                cyc(idle());
                o = idle(); o.hlt = 1'b1;
                cyc(o);
            end
        endcase
    endtask

    task automatic do_reset();
        cyc(idle(), 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic expect_halted(input int n);
        outs_t o;
        o = idle(); o.hlt = 1'b1;
        repeat (n) cyc(o, 1'b1, 1'b1, 1'b1);
        #3 lit("halted sticky", int'(halted), 1);
    endtask

    initial begin
        int exp_push[5];
        int exp_pop[4];
        exp_push = '{4, 0, 1, 2, 3};
        exp_pop  = '{8, 4, 2, 1};
        rst = 1'b1; IR_out = 8'h00; flag_out = 8'h00;
        mem_ready = 1'b1; stack_full = 1'b0; stack_empty = 1'b0;

        do_reset();
        #3;
        lit("reset mux1", int'(Mux_1_sel), 5);
        lit("reset opcode", int'(opcode), 3);
        do_reset();

        do_instr(8'h13, 8'h00);
        #3;
        lit("sub opcode", int'(opcode), 1);
        lit("sub load_Reg_Z", int'(load_Reg_Z), 1);

        rd_cnt = 0; ldir_cnt = 0; inc_cnt = 0; cnt_en = 1'b1;
        do_instr(8'h13, 8'h00, 3);
        #3 cnt_en = 1'b0;
        lit("stalled fetch reads", rd_cnt, 4);
        lit("stalled fetch load_IR", ldir_cnt, 1);
        lit("stalled fetch inc_PC", inc_cnt, 1);

        do_instr(8'h00, 8'h00);
        do_instr(8'h2B, 8'h00, 1);
        do_instr(8'h6E, 8'h00);
        do_instr(8'h79, 8'h00, 1);
        do_instr(8'h31, 8'h00, 2);
        do_instr(8'h42, 8'h00);
        do_instr(8'h87, 8'h00, 1);
        do_instr(8'h50, 8'h00, 1);

        do_instr(8'h92, 8'h00);
        #3 lit("brc not taken inc_PC", int'(inc_PC), 1);
        do_instr(8'h92, 8'h04);
        #3 lit("brc taken load_PC", int'(load_PC), 1);
        do_instr(8'h97, 8'h80, 2);
        do_instr(8'h90, 8'hFE);

        push_q.delete();
        do_instr(8'hA0, 8'h00);
        lit("call push count", push_q.size(), 5);
        for (int i = 0; i < 5 && i < push_q.size(); i++) lit("call push mux1", push_q[i], exp_push[i]);
        pop_q.delete();
        do_instr(8'hB0, 8'h00);
        lit("ret pop count", pop_q.size(), 4);
        for (int i = 0; i < 4 && i < pop_q.size(); i++) lit("ret pop load_reg", pop_q[i], exp_pop[i]);

        do_instr(8'hA0, 8'h00, 0, 2, 1);
        #3 lit("stack full push", int'(push), 0);
        expect_halted(2);
        do_reset();

        do_instr(8'hB0, 8'h00, 0, 1, 1);
        #3 lit("stack empty pop", int'(pop), 0);
        expect_halted(1);
        do_reset();

        do_instr(8'hF0, 8'h00);
        expect_halted(2);
        do_reset();

        do_instr(8'hA0, 8'h00, 0, 3, 2);
        do_reset();
        do_instr(8'h13, 8'h00);

        @(negedge clk);
        exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
